// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the memory-side bus responder.
//   - rd_state_e  : read FSM encoding (idle / latency wait / response offered)
//   - WordOffset  : byte-to-word address shift for 32-bit words
//   - LatCntWidth : width of the read latency counter (latency 1..15)
//   - lat_load()  : counter preload for a given read latency
package bus_mem_responder_pkg;

  localparam int unsigned WordOffset  = 2;
  localparam int unsigned LatCntWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } rd_state_e;

  // The wait state lasts (lat - 1) cycles; the counter counts down to zero, so it
  // starts at lat - 2. Latency 1 never enters the wait state.
  function automatic logic [LatCntWidth-1:0] lat_load(input int unsigned lat);
    logic [LatCntWidth-1:0] v;
    v = '0;
    if (lat > 1) v = LatCntWidth'(lat - 2);
    return v;
  endfunction

endpackage

// File: rtl/bus_mem_responder_mem_array.sv
// Word-organised RAM: one write port, one synchronous read port.
// Ports:
//   i_clk             clock
//   i_we/i_waddr/i_wdata   write enable, word index, data
//   i_re/i_raddr      read enable, word index (sampled on the clock edge)
//   o_rdata           registered read data; holds its value while i_re is low
// A read and write to the same word on the same edge returns the old contents.
module bus_mem_responder_mem_array #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 1024,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the valid/ready bus (raddr/rdata/waddr/wdata channels).
// Services one outstanding read with programmable latency and pairs independently
// arriving write address and write data beats into a single RAM write.
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_raddr_valid/o_raddr_ready/i_raddr   read address channel (byte address)
//   o_rdata_valid/i_rdata_ready/o_rdata   read data channel
//   i_waddr_valid/o_waddr_ready/i_waddr   write address channel (byte address)
//   i_wdata_valid/o_wdata_ready/i_wdata   write data channel (full word)
//   o_misaligned                     sticky flag, only with BUS_MEM_RESPONDER_ALIGN_CHECK_EN
// Configuration macro: BUS_MEM_RESPONDER_ALIGN_CHECK_EN adds o_misaligned, which is set
// when an accepted read or write address has nonzero low two bits; cleared only by reset.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned bus_width    = 32,
  parameter int unsigned mem_depth    = 1024,
  parameter int unsigned read_latency = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_raddr_valid,
  output logic                 o_raddr_ready,
  input  logic [bus_width-1:0] i_raddr,
  output logic                 o_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic [bus_width-1:0] o_rdata,
  input  logic                 i_waddr_valid,
  output logic                 o_waddr_ready,
  input  logic [bus_width-1:0] i_waddr,
  input  logic                 i_wdata_valid,
  output logic                 o_wdata_ready,
`ifdef BUS_MEM_RESPONDER_ALIGN_CHECK_EN
  output logic                 o_misaligned,
`endif
  input  logic [bus_width-1:0] i_wdata
);

  localparam int unsigned AddrW = $clog2(mem_depth);

  // Read path state
  rd_state_e              r_state;
  logic [LatCntWidth-1:0] r_lat_cnt;
  logic                   r_raddr_ready;
  logic                   r_rdata_valid;

  // Write pairing buffers
  logic                 r_waddr_full;
  logic                 r_wdata_full;
  logic                 r_waddr_ready;
  logic                 r_wdata_ready;
  logic [AddrW-1:0]     r_waddr_idx;
  logic [bus_width-1:0] r_wdata;

  logic                 w_waddr_full_d;
  logic                 w_wdata_full_d;

  logic                 w_raddr_fire;
  logic                 w_waddr_fire;
  logic                 w_wdata_fire;
  logic                 w_commit;
  logic [AddrW-1:0]     w_raddr_idx;
  logic [AddrW-1:0]     w_waddr_idx;
  logic [bus_width-1:0] w_mem_rdata;

  assign w_raddr_fire = i_raddr_valid & r_raddr_ready;
  assign w_waddr_fire = i_waddr_valid & r_waddr_ready;
  assign w_wdata_fire = i_wdata_valid & r_wdata_ready;
  assign w_commit     = r_waddr_full & r_wdata_full;

  // Upper address bits alias onto the RAM.
  assign w_raddr_idx = i_raddr[WordOffset +: AddrW];
  assign w_waddr_idx = i_waddr[WordOffset +: AddrW];

  logic w_unused_addr;
  assign w_unused_addr = ^{i_raddr[bus_width-1:WordOffset+AddrW], i_raddr[WordOffset-1:0],
                           i_waddr[bus_width-1:WordOffset+AddrW], i_waddr[WordOffset-1:0]};

  bus_mem_responder_mem_array #(
    .Width (bus_width),
    .Depth (mem_depth)
  ) u_mem_array (
    .i_clk   (i_clk),
    .i_we    (w_commit),
    .i_waddr (r_waddr_idx),
    .i_wdata (r_wdata),
    .i_re    (w_raddr_fire),
    .i_raddr (w_raddr_idx),
    .o_rdata (w_mem_rdata)
  );

  // Read FSM. The RAM word is captured on the accept edge and the RAM output register
  // holds it (no further read enable) until the response completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_lat_cnt     <= '0;
      r_raddr_ready <= 1'b0;
      r_rdata_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_raddr_fire) begin
            r_raddr_ready <= 1'b0;
            if (read_latency <= 1) begin
              r_state       <= StResp;
              r_rdata_valid <= 1'b1;
            end else begin
              r_state   <= StWait;
              r_lat_cnt <= lat_load(read_latency);
            end
          end else begin
            // Also covers the first cycle after reset, where ready was held low.
            r_raddr_ready <= 1'b1;
          end
        end
        StWait: begin
          if (r_lat_cnt == '0) begin
            r_state       <= StResp;
            r_rdata_valid <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        StResp: begin
          if (i_rdata_ready) begin
            r_state       <= StIdle;
            r_rdata_valid <= 1'b0;
            r_raddr_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= StIdle;
          r_lat_cnt     <= '0;
          r_raddr_ready <= 1'b0;
          r_rdata_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_raddr_ready = r_raddr_ready;
  assign o_rdata_valid = r_rdata_valid;
  // Zero outside the response so reset and idle present a clean bus.
  assign o_rdata       = r_rdata_valid ? w_mem_rdata : '0;

  // Write buffer occupancy. A commit empties both buffers; ready cannot be high while a
  // buffer is full, so commit and a new fire never coincide on the same buffer.
  always_comb begin
    w_waddr_full_d = r_waddr_full;
    w_wdata_full_d = r_wdata_full;
    if (w_commit) begin
      w_waddr_full_d = 1'b0;
      w_wdata_full_d = 1'b0;
    end else begin
      if (w_waddr_fire) w_waddr_full_d = 1'b1;
      if (w_wdata_fire) w_wdata_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_waddr_full  <= 1'b0;
      r_wdata_full  <= 1'b0;
      r_waddr_ready <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_waddr_idx   <= '0;
      r_wdata       <= '0;
    end else begin
      r_waddr_full  <= w_waddr_full_d;
      r_wdata_full  <= w_wdata_full_d;
      // Registered ready tracks buffer emptiness but stays low through reset.
      r_waddr_ready <= ~w_waddr_full_d;
      r_wdata_ready <= ~w_wdata_full_d;
      if (w_waddr_fire) r_waddr_idx <= w_waddr_idx;
      if (w_wdata_fire) r_wdata     <= i_wdata;
    end
  end

  assign o_waddr_ready = r_waddr_ready;
  assign o_wdata_ready = r_wdata_ready;

`ifdef BUS_MEM_RESPONDER_ALIGN_CHECK_EN
  logic r_misaligned;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_misaligned <= 1'b0;
    end else if ((w_raddr_fire && (i_raddr[WordOffset-1:0] != '0)) ||
                 (w_waddr_fire && (i_waddr[WordOffset-1:0] != '0))) begin
      r_misaligned <= 1'b1;
    end
  end

  assign o_misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed testbench for bus_mem_responder (bus_width=32, mem_depth=1024, read_latency=2).
module tb_bus_mem_responder;

  logic        clk;
  logic        rst;
  logic        raddr_valid;
  logic        raddr_ready;
  logic [31:0] raddr;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic        waddr_valid;
  logic        waddr_ready;
  logic [31:0] waddr;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
`ifdef BUS_MEM_RESPONDER_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bus_mem_responder #(
    .bus_width    (32),
    .mem_depth    (1024),
    .read_latency (2)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_raddr_valid (raddr_valid),
    .o_raddr_ready (raddr_ready),
    .i_raddr       (raddr),
    .o_rdata_valid (rdata_valid),
    .i_rdata_ready (rdata_ready),
    .o_rdata       (rdata),
    .i_waddr_valid (waddr_valid),
    .o_waddr_ready (waddr_ready),
    .i_waddr       (waddr),
    .i_wdata_valid (wdata_valid),
    .o_wdata_ready (wdata_ready),
`ifdef BUS_MEM_RESPONDER_ALIGN_CHECK_EN
    .o_misaligned  (misaligned),
`endif
    .i_wdata       (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_accept(input logic [31:0] addr);
    raddr       = addr;
    raddr_valid = 1'b1;
    for (int i = 0; i < 50 && !raddr_ready; i++) tick();
    check("raddr_ready_before_accept", {31'b0, raddr_ready}, 32'd1);
    tick();
    raddr_valid = 1'b0;
  endtask

  // Cycles from the accept edge until rdata_valid is seen.
  task automatic rd_wait(output int lat);
    lat = 1;
    while (!rdata_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic rd_take();
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    rd_accept(addr);
    rd_wait(lat);
    data = rdata;
    rd_take();
  endtask

  task automatic wr_addr(input logic [31:0] addr);
    waddr       = addr;
    waddr_valid = 1'b1;
    for (int i = 0; i < 50 && !waddr_ready; i++) tick();
    check("waddr_ready_before_accept", {31'b0, waddr_ready}, 32'd1);
    tick();
    waddr_valid = 1'b0;
  endtask

  task automatic wr_data(input logic [31:0] data);
    wdata       = data;
    wdata_valid = 1'b1;
    for (int i = 0; i < 50 && !wdata_ready; i++) tick();
    check("wdata_ready_before_accept", {31'b0, wdata_ready}, 32'd1);
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    wr_addr(addr);
    wr_data(data);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;

    rst         = 1'b1;
    raddr_valid = 1'b0;
    raddr       = '0;
    rdata_ready = 1'b0;
    waddr_valid = 1'b0;
    waddr       = '0;
    wdata_valid = 1'b0;
    wdata       = '0;

    // Reset state
    repeat (2) tick();
    check("rst_raddr_ready", {31'b0, raddr_ready}, 32'd0);
    check("rst_waddr_ready", {31'b0, waddr_ready}, 32'd0);
    check("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
    check("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_raddr_ready", {31'b0, raddr_ready}, 32'd1);
    check("post_rst_waddr_ready", {31'b0, waddr_ready}, 32'd1);
    check("post_rst_wdata_ready", {31'b0, wdata_ready}, 32'd1);

    // Write with address first, data three cycles later
    wr_addr(32'h100);
    check("waddr_buf_full_ready", {31'b0, waddr_ready}, 32'd0);
    check("wdata_still_ready", {31'b0, wdata_ready}, 32'd1);
    repeat (3) tick();
    wr_data(32'hDEADBEEF);
    tick();
    do_read(32'h100, d, lat);
    check("rd100_latency", lat, 32'd2);
    check("rd100_data", d, 32'hDEADBEEF);

    // Backpressure: response held for five cycles
    rd_accept(32'h100);
    rd_wait(lat);
    check("bp_latency", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rdata_valid", {31'b0, rdata_valid}, 32'd1);
      check("bp_rdata", rdata, 32'hDEADBEEF);
      check("bp_raddr_ready", {31'b0, raddr_ready}, 32'd0);
      tick();
    end
    rd_take();
    check("bp_done_valid", {31'b0, rdata_valid}, 32'd0);
    check("bp_done_raddr_ready", {31'b0, raddr_ready}, 32'd1);

    // Collision: write commit and read accept on the same edge
    do_write(32'h40, 32'h1);
    for (int i = 0; i < 50 && !(waddr_ready && wdata_ready && raddr_ready); i++) tick();
    waddr       = 32'h40;
    wdata       = 32'h2;
    waddr_valid = 1'b1;
    wdata_valid = 1'b1;
    tick();
    waddr_valid = 1'b0;
    wdata_valid = 1'b0;
    raddr       = 32'h40;
    raddr_valid = 1'b1;
    check("coll_raddr_ready", {31'b0, raddr_ready}, 32'd1);
    tick();
    raddr_valid = 1'b0;
    rd_wait(lat);
    check("coll_latency", lat, 32'd2);
    check("coll_old_data", rdata, 32'h1);
    rd_take();
    do_read(32'h40, d, lat);
    check("coll_new_data", d, 32'h2);

    // Aliasing: upper address bits wrap onto the RAM
    do_write(32'h1000, 32'hA5A5A5A5);
    do_read(32'h0000, d, lat);
    check("alias_data", d, 32'hA5A5A5A5);

    // Wdata first, then waddr
    wr_data(32'hCAFE0001);
    check("wdata_first_ready", {31'b0, wdata_ready}, 32'd0);
    wr_addr(32'h204);
    tick();
    do_read(32'h204, d, lat);
    check("wdata_first_data", d, 32'hCAFE0001);

`ifdef BUS_MEM_RESPONDER_ALIGN_CHECK_EN
    check("align_clear", {31'b0, misaligned}, 32'd0);
    do_read(32'h103, d, lat);
    check("align_rd_data", d, 32'hDEADBEEF);
    check("align_set", {31'b0, misaligned}, 32'd1);
    do_read(32'h100, d, lat);
    check("align_sticky", {31'b0, misaligned}, 32'd1);
`endif

    // Reset in the middle of a response
    rd_accept(32'h100);
    rd_wait(lat);
    check("mid_rst_pre_valid", {31'b0, rdata_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_raddr_ready", {31'b0, raddr_ready}, 32'd0);
`ifdef BUS_MEM_RESPONDER_ALIGN_CHECK_EN
    check("align_rst_clear", {31'b0, misaligned}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    check("mid_rst_ready_lag", {31'b0, raddr_ready}, 32'd0);
    tick();
    check("mid_rst_ready_back", {31'b0, raddr_ready}, 32'd1);
    check("mid_rst_valid_low", {31'b0, rdata_valid}, 32'd0);

    // Reset discards a half-filled write pair
    wr_addr(32'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wr_data(32'h12345678);
    repeat (2) tick();
    check("half_pair_waddr_empty", {31'b0, waddr_ready}, 32'd1);
    wr_addr(32'h300);
    tick();
    do_read(32'h300, d, lat);
    check("half_pair_data", d, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
